// File: rtl/bft_pkt_pkg.sv
// bft_pkt_pkg: shared packet layout, mode codes, FSM states and saturating add
package bft_pkt_pkg;
   localparam logic [1:0] MODE_IDLE = 2'd0;
   localparam logic [1:0] MODE_LOOP = 2'd1;
   localparam logic [1:0] MODE_GEN = 2'd2;
   typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
   function automatic int addr_w(int num_leaves);
      return $clog2(num_leaves);
   endfunction
   function automatic int valid_pos(int num_leaves, int payload_sz);
      return 2 * addr_w(num_leaves) + payload_sz;
   endfunction
   function automatic int dst_lsb(int num_leaves, int payload_sz);
      return addr_w(num_leaves) + payload_sz;
   endfunction
   function automatic int src_lsb(int payload_sz);
      return payload_sz;
   endfunction
   function automatic int payload_lsb();
      return 0;
   endfunction
   function automatic logic [31:0] sat_add(logic [31:0] v, logic [1:0] inc, int w);
      logic [32:0] s, m;
      s = {1'b0, v} + {31'b0, inc};
      m = (33'd1 << w) - 33'd1;
      return s > m ? m[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/bft_leaf_traffic_pe_if.sv
// bft_leaf_traffic_pe_if: leaf-to-network packet link with retry strobe
interface bft_leaf_traffic_pe_if #(parameter int P_SZ = 60);
   logic [P_SZ-1:0] pe_interface;
   logic [P_SZ-1:0] interface_pe;
   logic resend;
   modport master(output pe_interface, input interface_pe, resend);
   modport slave(input pe_interface, output interface_pe, resend);
endinterface

// File: rtl/bft_tx_hold.sv
// bft_tx_hold: transmit holding register that keeps rejected packets for retry
module bft_tx_hold #(parameter int P_SZ = 60) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            load_v,
   input  logic [P_SZ-1:0] load_pkt,
   input  logic            resend,
   output logic [P_SZ-1:0] pkt,
   output logic            held,
   output logic            accept
);
   assign held = pkt[P_SZ-1] & resend;
   assign accept = pkt[P_SZ-1] & ~resend;
   // Keep a rejected packet, otherwise take the next one or go empty
   always_ff @(posedge clk)
      if (reset || clr) pkt <= '0;
      else if (!held) pkt <= load_v ? load_pkt : '0;
endmodule

// File: rtl/bft_leaf_traffic_pe.sv
// bft_leaf_traffic_pe: BFT leaf endpoint with loopback, traffic generation and counters
module bft_leaf_traffic_pe import bft_pkt_pkg::*; #(
   parameter int NUM_LEAVES = 256,
   parameter int PAYLOAD_SZ = 43,
   parameter int P_SZ = 1 + 2 * $clog2(NUM_LEAVES) + PAYLOAD_SZ,
   parameter int ADDR = 0,
   parameter int CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [1:0]                     mode,
   input  logic                           start,
   input  logic [CNT_W-1:0]               num_pkts,
   input  logic [addr_w(NUM_LEAVES)-1:0]  dst_base,
   input  logic [addr_w(NUM_LEAVES)-1:0]  dst_stride,
   bft_leaf_traffic_pe_if.master          link,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_W-1:0]               sent_cnt,
   output logic [CNT_W-1:0]               rcvd_cnt,
   output logic [CNT_W-1:0]               err_cnt,
   output logic [P_SZ-1:0]                last_rx
);
   localparam int ADDR_W = addr_w(NUM_LEAVES);
   localparam int VB = valid_pos(NUM_LEAVES, PAYLOAD_SZ);
   localparam int DL = dst_lsb(NUM_LEAVES, PAYLOAD_SZ);
   localparam int SL = src_lsb(PAYLOAD_SZ);
   localparam int PLB = payload_lsb();
   localparam logic [ADDR_W-1:0] ME = ADDR_W'(ADDR);
   state_t state, nxt;
   logic s1, s2, s3, rise;
   logic [CNT_W-1:0] k;
   logic [ADDR_W-1:0] dst;
   logic enter, zero_run, abort, finish, load_v, drop, held, accept;
   logic [P_SZ-1:0] load_pkt;
   logic rx_v;
   logic [ADDR_W-1:0] rx_dst, rx_src;
   logic [PAYLOAD_SZ-1:0] rx_pl;
   logic [1:0] err_inc;
   assign rx_v = link.interface_pe[VB];
   assign rx_dst = link.interface_pe[DL +: ADDR_W];
   assign rx_src = link.interface_pe[SL +: ADDR_W];
   assign rx_pl = link.interface_pe[PLB +: PAYLOAD_SZ];
   assign rise = s2 & ~s3;
   assign busy = state == GEN;
   assign err_inc = {1'b0, rx_v && rx_dst != ME} + {1'b0, drop};
   // Two-flop start synchroniser plus edge-detect history
   always_ff @(posedge clk)
      if (reset) {s3, s2, s1} <= '0;
      else {s3, s2, s1} <= {s2, s1, start};
   // Run FSM state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : nxt;
   // Next state and the packet offered to the holding register
   always_comb begin
      nxt = state;
      enter = 1'b0;
      zero_run = 1'b0;
      abort = 1'b0;
      finish = 1'b0;
      load_v = 1'b0;
      load_pkt = '0;
      drop = 1'b0;
      case (state)
         IDLE:
            if (mode == MODE_GEN && rise) begin
               if (num_pkts != '0) begin
                  nxt = GEN;
                  enter = 1'b1;
                  load_v = 1'b1;
                  load_pkt = {1'b1, dst_base, ME, {PAYLOAD_SZ{1'b0}}};
               end else zero_run = 1'b1;
            end else if (mode == MODE_LOOP && rx_v) begin
               drop = held;
               load_v = 1'b1;
               load_pkt = {1'b1, rx_src, ME, rx_pl + PAYLOAD_SZ'(1)};
            end
         GEN:
            if (mode != MODE_GEN) begin
               abort = 1'b1;
               nxt = IDLE;
            end else if (accept) begin
               if (k + CNT_W'(1) >= num_pkts) begin
                  finish = 1'b1;
                  nxt = DONE;
               end else begin
                  load_v = 1'b1;
                  load_pkt = {1'b1, dst + dst_stride, ME, PAYLOAD_SZ'(k + CNT_W'(1))};
               end
            end
         DONE: nxt = s2 ? DONE : IDLE;
         default: nxt = IDLE;
      endcase
   end
   // Packet index and accumulated destination advance only on acceptance
   always_ff @(posedge clk)
      if (reset) begin
         k <= '0;
         dst <= '0;
      end else if (enter) begin
         k <= '0;
         dst <= dst_base;
      end else if (state == GEN && accept) begin
         k <= k + CNT_W'(1);
         dst <= dst + dst_stride;
      end
   // Sticky run-complete flag
   always_ff @(posedge clk)
      if (reset || enter) done <= 1'b0;
      else if (zero_run || finish) done <= 1'b1;
   // Saturating counters and last received packet
   always_ff @(posedge clk)
      if (reset) begin
         sent_cnt <= '0;
         rcvd_cnt <= '0;
         err_cnt <= '0;
         last_rx <= '0;
      end else begin
         sent_cnt <= enter ? '0 : CNT_W'(sat_add(32'(sent_cnt), {1'b0, accept}, CNT_W));
         err_cnt <= enter ? '0 : CNT_W'(sat_add(32'(err_cnt), err_inc, CNT_W));
         rcvd_cnt <= CNT_W'(sat_add(32'(rcvd_cnt), {1'b0, rx_v}, CNT_W));
         if (rx_v) last_rx <= link.interface_pe;
      end
   bft_tx_hold #(.P_SZ(P_SZ)) u_tx (
      .clk(clk),
      .reset(reset),
      .clr(abort),
      .load_v(load_v),
      .load_pkt(load_pkt),
      .resend(link.resend),
      .pkt(link.pe_interface),
      .held(held),
      .accept(accept)
   );
endmodule

// File: doc/bft_leaf_traffic_pe.md
Name: bft_leaf_traffic_pe

Overview:
- Parametrised leaf endpoint for the butterfly-fat-tree (BFT) network test harness.
- Supersedes the fixed start/shift endpoints with one module and three modes: idle, loopback-reply and traffic-generate.
- Retries packets the network rejects via `resend`, instead of dropping them.
- Checks received packets and exposes send/receive/error counters for network bring-up and characterisation.

Parameters:
- NUM_LEAVES, 256: number of leaves in the network; ADDR_W = $clog2(NUM_LEAVES).
- PAYLOAD_SZ, 43: payload field width.
- P_SZ, 1+2*ADDR_W+PAYLOAD_SZ: packet width.
- ADDR, 0: this leaf's own address.
- CNT_W, 16: width of every counter and of `num_pkts`.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  0 = idle, 1 = loopback, 2 = generate, 3 = reserved (treated as idle)
- start  in  1  level input; a rising edge launches a generate run
- num_pkts  in  CNT_W  packets to send per run
- dst_base  in  ADDR_W  first destination address
- dst_stride  in  ADDR_W  destination increment per packet
- pe_interface  out  P_SZ  packet to the network
- interface_pe  in  P_SZ  packet from the network
- resend  in  1  network rejected the packet currently on `pe_interface`
- busy  out  1  generate run in progress
- done  out  1  run complete (sticky)
- sent_cnt  out  CNT_W  packets accepted by the network
- rcvd_cnt  out  CNT_W  valid packets received
- err_cnt  out  CNT_W  misrouted packets plus dropped loopback replies
- last_rx  out  P_SZ  most recent valid received packet

Behaviour:
- Packet format, MSB first: {valid, dst[ADDR_W], src[ADDR_W], payload[PAYLOAD_SZ]}.
- A packet counts as transmitted only if it is presented and `resend` is low in the same cycle.
- On reset: all outputs are 0, the FSM enters IDLE, and the `start` edge detector is cleared.
- `start` passes through a 2-flop synchroniser. A rising edge is detected at stage 2, giving 3 cycles from the `start` edge to the first valid packet.
- Transmit holding register (tx_reg), which drives `pe_interface`:
  - If valid and `resend` = 1: tx_reg keeps the same value next cycle.
  - If valid and `resend` = 0: tx_reg is loaded with the next packet, or cleared to 0 if there is none.
- FSM:
  - IDLE → GEN when mode == 2, a `start` rising edge is detected, and num_pkts != 0. On entry: clear `done`, `sent_cnt` and `err_cnt`; set k = 0.
  - If num_pkts == 0 on a `start` edge: set `done` the next cycle and stay in IDLE.
  - GEN: tx packet = {1, dst_k, ADDR, payload = k zero-extended}, where dst_k = dst_base + k*dst_stride mod 2^ADDR_W (accumulated with wraparound, no multiplier).
  - GEN: k advances only on acceptance. After the num_pkts-th acceptance → DONE.
  - GEN: `busy` = 1.
  - DONE: `done` = 1 and `busy` = 0. Return to IDLE on the cycle after `start` is seen low at stage 2.
  - A mode change away from 2 while in GEN aborts the run:
    - tx_reg is cleared immediately, even if `resend` is high.
    - FSM → IDLE with `done` = 0.
- Loopback (mode 1, FSM in IDLE):
  - A valid rx {1, d, s, p} produces the reply {1, s, ADDR, p+1}, with the payload wrapping modulo 2^PAYLOAD_SZ.
  - The reply is loaded into tx_reg one cycle after receipt.
  - If tx_reg is still held by `resend` when a new valid packet arrives, that reply is dropped and `err_cnt`++.
- Receive path (all modes):
  - Every valid `interface_pe` increments `rcvd_cnt` and updates `last_rx` in the next cycle.
  - If the received dst != ADDR, `err_cnt`++.
- Counters saturate at all-ones and never wrap.
- If two `err_cnt` increment sources fire in the same cycle, `err_cnt` increases by 2 (still saturating).
- `rcvd_cnt` is cleared only by reset.
- Reset asserted mid-run: tx_reg is cleared the next edge, and no partial packet is ever emitted.

Decomposition:
- Shared package `bft_pkt_pkg` holds:
  - ADDR_W derivation, plus pkt_valid/dst/src/payload field offset functions, parametrised on NUM_LEAVES and PAYLOAD_SZ.
  - Mode constants MODE_IDLE, MODE_LOOP, MODE_GEN.
  - A saturating-increment function.
- One natural sub-module, `bft_tx_hold`: the tx holding register with its `resend` retry logic and acceptance strobe.

Test Plan:
- Reset run: mode = 2, num_pkts = 4, dst_base = 5, dst_stride = 3, `resend` = 0, `start` rising → 4 consecutive packets with dst 5, 8, 11, 14 and payloads 0–3, starting 3 cycles after the edge. Then `sent_cnt` = 4, `done` = 1, `busy` = 0.
- Backpressure: same run with `resend` = 1 for cycles 2–4 of the packet with payload 1 → that packet is held bit-identical for 3 cycles, then the sequence continues; `sent_cnt` = 4 with no duplicates or gaps.
- Wraparound: NUM_LEAVES = 16, dst_base = 14, dst_stride = 3, num_pkts = 3 → dst 14, 1, 4.
- Loopback: mode = 1, ADDR = 7, rx {1, 7, 9, 0x2A} → tx {1, 9, 7, 0x2B} one cycle later; `rcvd_cnt` = 1, `err_cnt` = 0.
- Errors: rx with dst = 3 at ADDR = 7 → `err_cnt` = 1. In loopback with `resend` held high, a second rx → reply dropped, `err_cnt` = 2.
- Abort: mode 2 → 0 mid-GEN while `resend` = 1 → `pe_interface` = 0 the next cycle, `busy` = 0, `done` = 0. Separately, num_pkts = 0 with a `start` edge → `done` = 1 and no packets sent.
